// File: rtl/shift_sequencer.sv
// Command sequencer for a universal shift register: turns load/shift/rotate
// commands into per-cycle mode, parallel-data and serial-input controls.
module shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 3
) (
    input  logic             clk,
    input  logic             CLRb,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNTW-1:0]  cmd_cnt,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             ser_in,
    input  logic [WIDTH-1:0] q_in,
    output logic             S1,
    output logic             S0,
    output logic [WIDTH-1:0] D,
    output logic             SDL,
    output logic             SDR,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        SHIFT = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t           state_r;
    logic [1:0]       op_r;
    logic [CNTW-1:0]  cnt_r;
    logic [1:0]       mode_r;
    logic [WIDTH-1:0] d_r;
    logic             ready_r;
    logic             busy_r;
    logic             done_r;
    logic             sdl_s;
    logic             sdr_s;

    // Register mode used while shifting: only plain shift right moves toward bit 0.
    function automatic logic [1:0] shift_mode(input logic [1:0] op);
        return (op == 2'b10) ? 2'b10 : 2'b01;
    endfunction

    // Bit that wraps around on rotate left.
    function automatic logic rotate_bit(input logic [WIDTH-1:0] q);
        return q[WIDTH-1];
    endfunction

    // Sequencer FSM; mode and D are set on the edge that enters each state.
    always_ff @(posedge clk or negedge CLRb) begin
        if (!CLRb) begin
            state_r <= IDLE;
            op_r    <= 2'b00;
            cnt_r   <= {CNTW{1'b0}};
            mode_r  <= 2'b00;
            d_r     <= {WIDTH{1'b0}};
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (cmd_valid) begin
                        op_r    <= cmd_op;
                        cnt_r   <= cmd_cnt;
                        ready_r <= 1'b0;
                        busy_r  <= 1'b1;
                        if (cmd_op == 2'b00) begin
                            state_r <= LOAD;
                            mode_r  <= 2'b11;
                            d_r     <= cmd_data;
                        end else begin
                            state_r <= SHIFT;
                            mode_r  <= shift_mode(cmd_op);
                            d_r     <= {WIDTH{1'b0}};
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LOAD: begin
                    state_r <= DONE;
                    mode_r  <= 2'b00;
                    d_r     <= {WIDTH{1'b0}};
                    done_r  <= 1'b1;
                end
                SHIFT: begin
                    // Count reaching zero marks the last of cnt+1 shift cycles.
                    if (cnt_r == {CNTW{1'b0}}) begin
                        state_r <= DONE;
                        mode_r  <= 2'b00;
                        done_r  <= 1'b1;
                    end else begin
                        cnt_r   <= cnt_r - CNTW'(1);
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    ready_r <= 1'b1;
                end
                default: begin
                    state_r <= IDLE;
                    mode_r  <= 2'b00;
                    d_r     <= {WIDTH{1'b0}};
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    // Serial inputs follow the live source so each shift sees the current bit.
    always_comb begin
        sdl_s = 1'b0;
        sdr_s = 1'b0;
        if (state_r == SHIFT) begin
            case (op_r)
                2'b01:   sdl_s = ser_in;
                2'b10:   sdr_s = ser_in;
                2'b11:   sdl_s = rotate_bit(q_in);
                default: begin
                    sdl_s = 1'b0;
                    sdr_s = 1'b0;
                end
            endcase
        end else begin
            sdl_s = 1'b0;
            sdr_s = 1'b0;
        end
    end

    assign cmd_ready = ready_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign S1        = mode_r[1];
    assign S0        = mode_r[0];
    assign D         = d_r;
    assign SDL       = sdl_s;
    assign SDR       = sdr_s;

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter WIDTH, default 8, data width of the universal shift register driven by this block.
REQ-002 Parameter CNTW, default 3, width of the shift-count field; the shift length is cmd_cnt+1, range 1..2^CNTW.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 CLRb  in  1  reset, asynchronous and active-low.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_ready  out  1  sequencer can accept a command.
REQ-007 cmd_op  in  2  operation: 00 load, 01 shift left, 10 shift right, 11 rotate left.
REQ-008 cmd_cnt  in  CNTW  shift length minus one; ignored for load.
REQ-009 cmd_data  in  WIDTH  parallel load word.
REQ-010 ser_in  in  1  serial data source for shift left and shift right.
REQ-011 q_in  in  WIDTH  current register contents, fed back from the register.
REQ-012 S1, S0  out  1 each  register mode: 00 hold, 01 shift left (SDL enters bit 0), 10 shift right (SDR enters bit WIDTH-1), 11 parallel load.
REQ-013 D  out  WIDTH  parallel data to the register.
REQ-014 SDL, SDR  out  1 each  serial inputs to the register.
REQ-015 busy  out  1  command in progress.
REQ-016 done  out  1  one-cycle completion pulse.

Function
REQ-017 The FSM SHALL have four states: IDLE, LOAD, SHIFT and DONE.
REQ-018 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a clock edge with cmd_valid=1 and cmd_ready=1.
REQ-019 On acceptance, op, cnt and data SHALL be captured; op 00 goes to LOAD, any other op goes to SHIFT with the remaining count set to cmd_cnt.
REQ-020 LOAD SHALL last exactly 1 cycle with {S1,S0}=11 and D=captured data, then go to DONE.
REQ-021 In SHIFT, {S1,S0} SHALL be 01 for ops 01/11 and 10 for op 10, each cycle.
REQ-022 SHIFT SHALL last exactly cnt+1 cycles: it decrements the remaining count each cycle and goes to DONE in the cycle where the count is 0.
REQ-023 Op 01: SDL=ser_in and SDR=0. Op 10: SDR=ser_in and SDL=0. Op 11: SDL=q_in[WIDTH-1] and SDR=0.
REQ-024 In IDLE and DONE, {S1,S0} SHALL be 00 and D, SDL and SDR SHALL be 0.
REQ-025 DONE SHALL last 1 cycle with done=1, then return to IDLE; done SHALL be 0 in all other states.
REQ-026 busy SHALL be 1 in LOAD, SHIFT and DONE, and 0 in IDLE.
REQ-027 All outputs SHALL be registered or decoded only from state and captured fields; there is no combinational path from cmd_* to S1/S0/D.
REQ-028 cmd_valid asserted while the block is not in IDLE SHALL be ignored; no command is queued.
REQ-029 Command-to-command spacing SHALL be at least 3 cycles (load) or cnt+3 cycles (shift), counting accept, operation, DONE and IDLE.
REQ-030 Maximum cmd_cnt (all ones) SHALL give 2^CNTW shift cycles with no wrap to 0.

Reset
REQ-031 CLRb=0 SHALL immediately force: state IDLE, count 0, captured fields 0, {S1,S0}=00, D=0, SDL=SDR=0, busy=0, done=0 and cmd_ready=1 once the block is out of reset.
REQ-032 Reset asserted mid-LOAD or mid-SHIFT SHALL abort the command with no done pulse; the first command after CLRb goes high is accepted normally.

Verification
REQ-033 Load: cmd_op=00, cmd_data=8'hA5 accepted at T -> at T+1 {S1,S0}=11 and D=A5; at T+2 done=1; at T+3 cmd_ready=1. With the register modelled, Q=A5.
REQ-034 Shift left: Q=8'h01, op=01, cnt=2, ser_in=1 -> exactly 3 cycles of mode 01, then Q=8'h0F, then one done pulse.
REQ-035 Rotate/shift right: Q=8'h81, op=11, cnt=0 -> Q=8'h03. Then op=10, cnt=7, ser_in=0 -> 8 shift cycles, Q=8'h00.
REQ-036 Busy rejection: cmd_valid held high during SHIFT with different data -> command ignored, cmd_ready=0 throughout, no extra cycles.
REQ-037 Reset abort: CLRb pulsed low for half a cycle during the 2nd cycle of cnt=5 shift -> outputs go to 0/hold asynchronously, done never pulses, and the next load completes correctly.
